// File: rtl/store_port_responder_pkg.sv
// Shared LSU types: packed store-port request/response layouts, field offsets and a byte-merge
// helper used by the store responder and its byte-enabled memory.
package store_port_responder_pkg;

  localparam int unsigned ReqWidth     = 77;
  localparam int unsigned RspWidth     = 35;
  localparam int unsigned ReqIndexLsb  = 65;
  localparam int unsigned ReqTagLsb    = 43;
  localparam int unsigned ReqWdataLsb  = 11;
  localparam int unsigned ReqWuserBit  = 10;
  localparam int unsigned ReqReqBit    = 9;
  localparam int unsigned ReqWeBit     = 8;
  localparam int unsigned ReqBeLsb     = 4;
  localparam int unsigned ReqSizeLsb   = 2;
  localparam int unsigned ReqKillBit   = 1;
  localparam int unsigned ReqTagVldBit = 0;
  localparam int unsigned RspGntBit    = 34;
  localparam int unsigned RspRvalidBit = 33;
  localparam int unsigned RspRdataLsb  = 1;
  localparam int unsigned RspRuserBit  = 0;

  typedef struct packed {
    logic [11:0] address_index;
    logic [21:0] address_tag;
    logic [31:0] data_wdata;
    logic        data_wuser;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [1:0]  data_size;
    logic        kill_req;
    logic        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        data_ruser;
  } dcache_req_o_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_port_responder_be_mem.sv
// Word memory with one byte-enabled synchronous write port and one asynchronous read port;
// the whole array clears on reset.
module be_mem
  import store_port_responder_pkg::*;
#(
  parameter int unsigned Words = 64,
  localparam int unsigned Aw   = $clog2(Words)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [Aw-1:0] waddr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  input  logic [Aw-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Words); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= be_merge(mem_q[waddr_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_port_responder.sv
// Store-only dcache port responder: grants write requests after a configurable delay,
// commits them into a byte-enabled memory, counts writes and flags protocol errors.
module store_port_responder
  import store_port_responder_pkg::*;
#(
  parameter int unsigned GNT_DELAY = 0,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ReqWidth-1:0]          req_port_i,
  output logic [RspWidth-1:0]          req_port_o,
  input  logic                         busy_i,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr_i,
  output logic [31:0]                  dbg_data_o,
  output logic [15:0]                  wr_count_o,
  output logic                         err_o
);

  localparam int unsigned Aw = $clog2(MEM_WORDS);
  localparam logic [2:0] WaitLoad = (GNT_DELAY == 0) ? 3'd0 : 3'(GNT_DELAY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StGrant} state_e;

  state_e        state_q;
  logic [2:0]    wait_cnt_q;
  logic [15:0]   wr_count_q;
  logic          err_q;
  dcache_req_i_t req;
  dcache_req_o_t rsp;
  logic          valid;
  logic          gnt;
  logic          err_event;
  logic          unused;

  assign req   = dcache_req_i_t'(req_port_i);
  assign valid = req.data_req & req.data_we;

  // Gated by reset so the grant also drops asynchronously.
  assign gnt = rst_ni & valid & ~busy_i &
               ((state_q == StGrant) | ((state_q == StIdle) & (GNT_DELAY == 0)));

  assign err_event = (req.data_req & ~req.data_we) | req.kill_req |
                     (req.data_req & (req.data_be == 4'b0000));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (err_event) err_q <= 1'b1;
      if (gnt && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            if (GNT_DELAY == 0) begin
              if (!gnt) state_q <= StGrant;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (!valid) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q <= 3'd1) begin
            // Counter reaches zero on this edge: grant is offered next cycle.
            state_q    <= StGrant;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        StGrant: begin
          if (!valid || gnt) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  be_mem #(
    .Words (MEM_WORDS)
  ) u_be_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (gnt),
    .waddr_i (req.address_index[Aw+1:2]),
    .be_i    (req.data_be),
    .wdata_i (req.data_wdata),
    .raddr_i (dbg_addr_i),
    .rdata_o (dbg_data_o)
  );

  always_comb begin
    rsp             = '0;
    rsp.data_gnt    = gnt;
    rsp.data_rvalid = 1'b0;
    rsp.data_rdata  = '0;
    rsp.data_ruser  = 1'b0;
  end

  assign req_port_o = rsp;
  assign wr_count_o = wr_count_q;
  assign err_o      = err_q;

  // Tag, size, user and upper index bits carry no meaning for this store port.
  assign unused = ^{req.address_tag, req.address_index, req.data_wuser, req.data_size,
                    req.tag_valid};

endmodule

// File: tb/tb_store_port_responder.sv
// Bench for store_port_responder: three instances (GNT_DELAY 0/2/3) driven cycle by cycle,
// expected grants queued with stimulus and compared when the cycle is sampled.
module tb_store_port_responder;
  import store_port_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [76:0] req      [3];
  logic        busy     [3];
  logic [5:0]  dbg_addr [3];
  logic [34:0] rsp      [3];
  logic [31:0] dbg_data [3];
  logic [15:0] wr_count [3];
  logic        err      [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_gnt_q[$];

  always #5 clk = ~clk;

  store_port_responder #(.GNT_DELAY(0), .MEM_WORDS(64)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_port_i(req[0]), .req_port_o(rsp[0]), .busy_i(busy[0]),
    .dbg_addr_i(dbg_addr[0]), .dbg_data_o(dbg_data[0]), .wr_count_o(wr_count[0]),
    .err_o(err[0]));
  store_port_responder #(.GNT_DELAY(2), .MEM_WORDS(64)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_port_i(req[1]), .req_port_o(rsp[1]), .busy_i(busy[1]),
    .dbg_addr_i(dbg_addr[1]), .dbg_data_o(dbg_data[1]), .wr_count_o(wr_count[1]),
    .err_o(err[1]));
  store_port_responder #(.GNT_DELAY(3), .MEM_WORDS(64)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_port_i(req[2]), .req_port_o(rsp[2]), .busy_i(busy[2]),
    .dbg_addr_i(dbg_addr[2]), .dbg_data_o(dbg_data[2]), .wr_count_o(wr_count[2]),
    .err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [76:0] mk(input logic [11:0] idx, input logic [31:0] d,
                                     input logic [3:0] be, input logic rq, input logic we,
                                     input logic kill);
    dcache_req_i_t r;
    r               = '0;
    r.address_index = idx;
    r.address_tag   = 22'h3ABCD;
    r.data_wdata    = d;
    r.data_req      = rq;
    r.data_we       = we;
    r.data_be       = be;
    r.data_size     = 2'b10;
    r.kill_req      = kill;
    return r;
  endfunction

  // One clock cycle on unit u; starts just after a rising edge, ends just after the next.
  task automatic cyc(input int u, input logic [76:0] r, input logic b, input logic eg);
    logic e;
    req[u]  = r;
    busy[u] = b;
    exp_gnt_q.push_back(eg);
    @(negedge clk);
    e = exp_gnt_q.pop_front();
    check($sformatf("gnt_u%0d", u), {31'b0, rsp[u][34]}, {31'b0, e});
    check($sformatf("rsp_rest_u%0d", u), {31'b0, |rsp[u][33:0]}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input int u, input logic [5:0] a, input logic [31:0] e, input string tag);
    dbg_addr[u] = a;
    #1;
    check(tag, dbg_data[u], e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [76:0] r;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = '0; busy[i] = 1'b0; dbg_addr[i] = '0;
    end
    req[0] = mk(12'h004, 32'h11111111, 4'hF, 1'b1, 1'b1, 1'b0);
    #12;
    check("rst_gnt", {31'b0, rsp[0][34]}, 32'd0);
    check("rst_wr_count", {16'b0, wr_count[0]}, 32'd0);
    check("rst_err", {31'b0, err[0]}, 32'd0);
    mem(0, 6'd1, 32'd0, "rst_mem");
    req[0] = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back stores, first one in the first cycle after reset release.
    cyc(0, mk(12'h004, 32'h11111111, 4'hF, 1, 1, 0), 0, 1);
    cyc(0, mk(12'h008, 32'h22222222, 4'hF, 1, 1, 0), 0, 1);
    cyc(0, mk(12'h00C, 32'h33333333, 4'hF, 1, 1, 0), 0, 1);
    cyc(0, '0, 0, 0);
    mem(0, 6'd1, 32'h11111111, "b2b_w1");
    mem(0, 6'd2, 32'h22222222, "b2b_w2");
    mem(0, 6'd3, 32'h33333333, "b2b_w3");
    check("b2b_wr_count", {16'b0, wr_count[0]}, 32'd3);

    // Partial byte-enable overwrite.
    cyc(0, mk(12'h020, 32'hAABBCCDD, 4'hF, 1, 1, 0), 0, 1);
    cyc(0, mk(12'h020, 32'h00000011, 4'h1, 1, 1, 0), 0, 1);
    cyc(0, '0, 0, 0);
    mem(0, 6'd8, 32'hAABBCC11, "be_merge");
    check("be_wr_count", {16'b0, wr_count[0]}, 32'd5);

    // Backpressure: request held while busy, granted once busy falls.
    r = mk(12'h024, 32'h5A5A5A5A, 4'hF, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, r, 1, 0);
    cyc(0, r, 0, 1);
    cyc(0, '0, 0, 0);
    mem(0, 6'd9, 32'h5A5A5A5A, "busy_mem");
    check("busy_wr_count", {16'b0, wr_count[0]}, 32'd6);
    check("busy_err", {31'b0, err[0]}, 32'd0);

    // Read request: never granted, raises the sticky error.
    r = mk(12'h028, 32'hDEADBEEF, 4'hF, 1, 0, 0);
    cyc(0, r, 0, 0);
    check("rd_err", {31'b0, err[0]}, 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, r, 0, 0);
    cyc(0, '0, 0, 0);
    check("rd_err_sticky", {31'b0, err[0]}, 32'd1);
    check("rd_wr_count", {16'b0, wr_count[0]}, 32'd6);
    mem(0, 6'd10, 32'd0, "rd_mem");

    // GNT_DELAY=3: grant in request cycle 4, memory written at that edge.
    r = mk(12'h010, 32'hCAFEF00D, 4'hF, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(2, r, 0, 0);
    mem(2, 6'd4, 32'd0, "dly3_mem_pre");
    cyc(2, r, 0, 1);
    mem(2, 6'd4, 32'hCAFEF00D, "dly3_mem_post");
    cyc(2, '0, 0, 0);
    check("dly3_wr_count", {16'b0, wr_count[2]}, 32'd1);
    cyc(2, mk(12'h000, 32'h0, 4'h0, 0, 0, 1), 0, 0);
    cyc(2, '0, 0, 0);
    check("kill_err", {31'b0, err[2]}, 32'd1);

    // GNT_DELAY=2: drop in WAIT aborts, a later held request is granted in cycle 3.
    r = mk(12'h014, 32'h12345678, 4'hF, 1, 1, 0);
    cyc(1, r, 0, 0);
    cyc(1, '0, 0, 0);
    cyc(1, '0, 0, 0);
    check("abort_wr_count", {16'b0, wr_count[1]}, 32'd0);
    mem(1, 6'd5, 32'd0, "abort_mem");
    cyc(1, r, 0, 0);
    cyc(1, r, 0, 0);
    cyc(1, r, 0, 1);
    cyc(1, '0, 0, 0);
    mem(1, 6'd5, 32'h12345678, "dly2_mem");
    check("dly2_wr_count", {16'b0, wr_count[1]}, 32'd1);
    check("dly2_err", {31'b0, err[1]}, 32'd0);
    cyc(1, mk(12'h018, 32'hFFFFFFFF, 4'h0, 1, 1, 0), 0, 0);
    cyc(1, '0, 0, 0);
    check("be0_err", {31'b0, err[1]}, 32'd1);

    // Reset pulse clears state, counters, error and memory.
    rst_n = 1'b0;
    #1;
    check("rst2_err", {31'b0, err[0]}, 32'd0);
    check("rst2_wr_count", {16'b0, wr_count[0]}, 32'd0);
    mem(0, 6'd1, 32'd0, "rst2_mem1");
    mem(0, 6'd8, 32'd0, "rst2_mem8");
    check("rst2_err_u2", {31'b0, err[2]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, mk(12'h004, 32'h0F0F0F0F, 4'hF, 1, 1, 0), 0, 1);
    cyc(0, '0, 0, 0);
    mem(0, 6'd1, 32'h0F0F0F0F, "post_rst_mem");
    check("post_rst_wr_count", {16'b0, wr_count[0]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
